// File: rtl/fc_pkg.sv
// fc_pkg: shared FSM state type, width helper and output rounding/saturation for the FC stream engine.
package fc_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} fc_state_e;
  function automatic int clog2s(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  // Adds the bias at accumulator scale, floors back to FRAC_WIDTH and clamps to the DATA_WIDTH range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc, input logic signed [63:0] bias,
                                                   input int dw, input int fw);
    logic signed [63:0] s, hi, lo;
    s = (acc + (bias <<< fw)) >>> fw;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return (s > hi) ? hi : (s < lo) ? lo : s;
  endfunction
endpackage

// File: rtl/fc_lane.sv
// fc_lane: one MAC lane holding the running dot product and the neuron bias.
module fc_lane
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 12,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         beat_vld,
  input  logic                         first,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] w,
  input  logic                         b_vld,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic                         relu,
  output logic        [DATA_WIDTH-1:0] y
);
  logic signed [2*DATA_WIDTH-1:0] p;
  logic signed [ACC_WIDTH-1:0] acc_reg, prod;
  logic signed [DATA_WIDTH-1:0] bias_reg;
  logic signed [63:0] s;
  assign p = x * w;
  assign prod = ACC_WIDTH'(p);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg  <= '0;
      bias_reg <= '0;
    end else begin
      if (beat_vld) acc_reg <= first ? prod : acc_reg + prod;
      if (b_vld) bias_reg <= b;
    end
  end
  assign s = sat_round(64'(acc_reg), 64'(bias_reg), DATA_WIDTH, FRAC_WIDTH);
  assign y = (relu && s[63]) ? '0 : DATA_WIDTH'(s);
endmodule

// File: rtl/fc_stream_engine.sv
// fc_stream_engine: K-lane fully-connected layer engine, y = act(W*x + b), streaming x/W/b reads and
// ready-gated K-wide result groups.
module fc_stream_engine
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 12,
  parameter int ACC_WIDTH  = 40,
  parameter int IN_DIM     = 200,
  parameter int OUT_DIM    = 100,
  parameter int K          = 4,
  parameter int RD_LAT     = 1,
  localparam int XW  = clog2s(IN_DIM),
  localparam int WW  = clog2s(IN_DIM * OUT_DIM),
  localparam int BW  = clog2s(OUT_DIM),
  localparam int DCW = clog2s(RD_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  x_req,
  output logic [XW-1:0]         x_addr,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic [K-1:0]          w_req,
  output logic [WW-1:0]         w_addr   [0:K-1],
  input  logic [DATA_WIDTH-1:0] w_data   [0:K-1],
  output logic [K-1:0]          b_req,
  output logic [BW-1:0]         b_addr   [0:K-1],
  input  logic [DATA_WIDTH-1:0] b_data   [0:K-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BW-1:0]         out_base,
  output logic [K-1:0]          out_mask,
  output logic [DATA_WIDTH-1:0] out_data [0:K-1]
);
  if (ACC_WIDTH < 2 * DATA_WIDTH + $clog2(IN_DIM) || ACC_WIDTH > 64) begin : g_acc_chk
    $error("ACC_WIDTH out of range");
  end
  fc_state_e state;
  logic [BW-1:0] base;
  logic [XW-1:0] in_idx;
  logic [DCW-1:0] drain_cnt;
  logic [RD_LAT-1:0] vld_pipe, first_pipe;
  logic relu, fetch, wr;
  logic [K-1:0] lane_ok;
  logic [DATA_WIDTH-1:0] lane_y [0:K-1];
  assign fetch = state == FETCH;
  assign wr = state == WRITE;
  assign busy = fetch || state == DRAIN || wr;
  assign done = state == DONE;
  assign x_req = fetch;
  assign x_addr = fetch ? in_idx : '0;
  assign out_valid = wr;
  assign out_base = wr ? base : '0;
  assign out_mask = wr ? lane_ok : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      in_idx     <= '0;
      drain_cnt  <= '0;
      relu       <= 1'b0;
      vld_pipe   <= '0;
      first_pipe <= '0;
    end else begin
      vld_pipe   <= RD_LAT'({vld_pipe, fetch});
      first_pipe <= RD_LAT'({first_pipe, fetch && in_idx == '0});
      case (state)
        IDLE: if (start) begin
          base   <= '0;
          in_idx <= '0;
          relu   <= relu_en;
          state  <= FETCH;
        end
        FETCH: begin
          in_idx    <= (in_idx == XW'(IN_DIM - 1)) ? '0 : in_idx + 1'b1;
          drain_cnt <= '0;
          if (in_idx == XW'(IN_DIM - 1)) state <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DCW'(RD_LAT - 1)) state <= WRITE;
        end
        WRITE: if (out_ready) begin
          base  <= BW'(int'(base) + K);
          state <= (int'(base) + K >= OUT_DIM) ? DONE : FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Lanes past OUT_DIM see zero weight and bias, so they accumulate and output exactly 0.
  for (genvar k = 0; k < K; k++) begin : g_lane
    assign lane_ok[k] = int'(base) + k < OUT_DIM;
    assign w_req[k] = fetch && lane_ok[k];
    assign w_addr[k] = w_req[k] ? WW'((int'(base) + k) * IN_DIM + int'(in_idx)) : '0;
    assign b_req[k] = w_req[k] && in_idx == '0;
    assign b_addr[k] = b_req[k] ? BW'(int'(base) + k) : '0;
    fc_lane #(.DATA_WIDTH(DATA_WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk(clk), .rst(rst),
      .beat_vld(vld_pipe[RD_LAT-1]), .first(first_pipe[RD_LAT-1]),
      .x(x_data), .w(lane_ok[k] ? w_data[k] : '0),
      .b_vld(vld_pipe[RD_LAT-1] && first_pipe[RD_LAT-1]), .b(lane_ok[k] ? b_data[k] : '0),
      .relu(relu), .y(lane_y[k])
    );
    assign out_data[k] = out_mask[k] ? lane_y[k] : '0;
  end
endmodule
